// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg
//   Shared constants for the ALU issue stage: MIPS opcodes and funct codes
//   that the stage understands, the ALUop encodings the ALU control expects,
//   the hazard FSM state type, and small decode helpers.
package alu_issue_pkg;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_SLTI  = 6'd10;

    // R-type funct codes
    localparam logic [5:0] FN_AND   = 6'd36;
    localparam logic [5:0] FN_OR    = 6'd37;
    localparam logic [5:0] FN_ADD   = 6'd32;
    localparam logic [5:0] FN_SUB   = 6'd34;
    localparam logic [5:0] FN_SLT   = 6'd42;
    localparam logic [5:0] FN_SRL   = 6'd2;
    localparam logic [5:0] FN_MULTU = 6'd25;
    localparam logic [5:0] FN_MFHI  = 6'd16;
    localparam logic [5:0] FN_MFLO  = 6'd18;

    // ALUop encodings
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_SLT   = 2'b11;

    localparam int DEFAULT_MUL_LAT = 32;

    typedef enum logic {
        HZ_IDLE = 1'b0,
        HZ_BUSY = 1'b1
    } hz_state_t;

    // Funct codes the stage issues for opcode 0.
    function automatic logic is_rtype_funct(input logic [5:0] fn);
        return fn inside {FN_AND, FN_OR, FN_ADD, FN_SUB, FN_SLT,
                          FN_SRL, FN_MULTU, FN_MFHI, FN_MFLO};
    endfunction

    // Ops that touch HI/LO and therefore must wait out the multiplier.
    function automatic logic is_mul_dep(input logic [5:0] fn);
        return fn inside {FN_MULTU, FN_MFHI, FN_MFLO};
    endfunction

endpackage

// File: rtl/alu_issue_stage_mul_hazard_counter.sv
// mul_hazard_counter
//   Tracks the sequential multiplier's busy window.
//   Ports:
//     clk   - rising-edge clock
//     reset - asynchronous active-high reset
//     start - MULTU accepted this cycle (only honoured while idle)
//     busy  - registered; high while HI/LO is not yet valid
//   cnt is loaded with MUL_LAT and counts down once per cycle. The window
//   closes on the edge where cnt would step from 2 to 1, so busy is already
//   low during the cycle before edge N+MUL_LAT and a dependent op presented
//   then is accepted exactly on that edge.
module mul_hazard_counter
    import alu_issue_pkg::*;
#(
    parameter int MUL_LAT = DEFAULT_MUL_LAT
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic busy
);

    localparam int CW = $clog2(MUL_LAT + 1);

    hz_state_t     state;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= HZ_IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
        end else begin
            case (state)
                HZ_IDLE: begin
                    // A one-cycle multiplier never blocks the next edge.
                    if (start && (MUL_LAT > 1)) begin
                        state <= HZ_BUSY;
                        cnt   <= CW'(MUL_LAT);
                        busy  <= 1'b1;
                    end
                end
                HZ_BUSY: begin
                    if (cnt <= CW'(2)) begin
                        state <= HZ_IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: begin
                    state <= HZ_IDLE;
                    cnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage
//   Registered issue stage in front of the execute ALU. Decodes a MIPS
//   instruction plus its register operands into ALUop/Signal/dataA/dataB,
//   stalls HI/LO-dependent ops while the multiplier is busy, and converts
//   illegal encodings into bubbles with a one-cycle illegal pulse.
//   Ports:
//     clk, reset              - clock, asynchronous active-high reset
//     in_valid / in_ready     - input handshake (in_ready combinational)
//     instr, rs_data, rt_data - instruction word and operand values
//     out_valid               - issued op valid this cycle
//     ALUop, Signal           - ALU control inputs
//     dataA, dataB            - ALU operands
//     dest                    - destination register
//     mul_busy                - multiplier window open
//     illegal                 - pulse after an illegal instruction is accepted
module alu_issue_stage
    import alu_issue_pkg::*;
#(
    parameter int MUL_LAT = DEFAULT_MUL_LAT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        out_valid,
    output logic [1:0]  ALUop,
    output logic [5:0]  Signal,
    output logic [31:0] dataA,
    output logic [31:0] dataB,
    output logic [4:0]  dest,
    output logic        mul_busy,
    output logic        illegal
);

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [31:0] imm_sext;
    logic        is_rtype;
    logic        accept;
    logic        mul_start;

    logic        d_legal;
    logic [1:0]  d_aluop;
    logic [5:0]  d_signal;
    logic [31:0] d_a;
    logic [31:0] d_b;
    logic [4:0]  d_dest;

    // The rs index is not needed: its value arrives already read as rs_data.
    logic unused_rs;
    assign unused_rs = ^instr[25:21];

    assign opcode   = instr[31:26];
    assign funct    = instr[5:0];
    assign imm_sext = {{16{instr[15]}}, instr[15:0]};
    assign is_rtype = (opcode == OP_RTYPE);

    // Readiness looks at instr even when in_valid is low.
    assign in_ready  = !(mul_busy && is_rtype && is_mul_dep(funct));
    assign accept    = in_valid && in_ready;
    assign mul_start = accept && is_rtype && (funct == FN_MULTU);

    always_comb begin
        d_legal  = 1'b0;
        d_aluop  = '0;
        d_signal = '0;
        d_a      = '0;
        d_b      = '0;
        d_dest   = '0;
        case (opcode)
            OP_RTYPE: begin
                if (is_rtype_funct(funct)) begin
                    d_legal  = 1'b1;
                    d_aluop  = ALUOP_FUNCT;
                    d_signal = funct;
                    d_a      = rs_data;
                    d_b      = rt_data;
                    d_dest   = instr[15:11];
                    if (funct == FN_SRL) begin
                        d_a = rt_data;
                        d_b = {27'b0, instr[10:6]};
                    end
                    if (is_mul_dep(funct)) begin
                        d_dest = '0;
                    end
                end
            end
            OP_ADDI: begin
                d_legal  = 1'b1;
                d_aluop  = ALUOP_ADD;
                d_signal = FN_ADD;
                d_a      = rs_data;
                d_b      = imm_sext;
                d_dest   = instr[20:16];
            end
            OP_SLTI: begin
                d_legal  = 1'b1;
                d_aluop  = ALUOP_SLT;
                d_signal = FN_SLT;
                d_a      = rs_data;
                d_b      = imm_sext;
                d_dest   = instr[20:16];
            end
            default: ;
        endcase
    end

    // Bubbles drive every field to zero so the downstream multiplier sees
    // MULTU on Signal for exactly one cycle per issue.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            illegal   <= 1'b0;
            ALUop     <= '0;
            Signal    <= '0;
            dataA     <= '0;
            dataB     <= '0;
            dest      <= '0;
        end else begin
            out_valid <= accept && d_legal;
            illegal   <= accept && !d_legal;
            if (accept && d_legal) begin
                ALUop  <= d_aluop;
                Signal <= d_signal;
                dataA  <= d_a;
                dataB  <= d_b;
                dest   <= d_dest;
            end else begin
                ALUop  <= '0;
                Signal <= '0;
                dataA  <= '0;
                dataB  <= '0;
                dest   <= '0;
            end
        end
    end

    mul_hazard_counter #(
        .MUL_LAT (MUL_LAT)
    ) u_hazard (
        .clk   (clk),
        .reset (reset),
        .start (mul_start),
        .busy  (mul_busy)
    );

endmodule
